draw_board_datapath: RTL
========================

DRAW_BOARD_DATAPATH -- requirements
Module: draw_board_datapath

Interface
REQ-001 Parameter X_ORIGIN, default 8'd16: screen x of board square column 0, pixel 0.
REQ-002 Parameter Y_ORIGIN, default 7'd0: screen y of board square row 0, pixel 0.
REQ-003 clk  input  1  sole clock; all state SHALL change on its rising edge, except on reset.
REQ-004 resetn  input  1  asynchronous, active-low reset.
REQ-005 write  input  1  pixel request from the draw controller.
REQ-006 update_x_y  input  1  advance to the next board square.
REQ-007 draw_value  input  6  6'b011000 = background; 6'b011100 = turn marker; any other value = square content code.
REQ-008 long_counter  output  15  background pixel counter; {y[6:0], x[7:0]}.
REQ-009 counter  output  8  pixel index within a 16x16 square; {row[3:0], col[3:0]}.
REQ-010 x_y_pos  output  6  current square; [5:3] is row, [2:0] is column.
REQ-011 x  output  8  VGA pixel x.
REQ-012 y  output  7  VGA pixel y.
REQ-013 colour  output  3  VGA pixel colour, RGB.
REQ-014 plot  output  1  VGA write enable.

Function
REQ-015 Mode decode: background mode is write=1 with draw_value=6'b011000; piece mode is write=1 with any other draw_value, including 6'b011100.
REQ-016 Background mode: long_counter SHALL increment by 1 per cycle and wrap from 15'h7FFF to 0.
REQ-017 Piece mode: counter SHALL increment by 1 per cycle and wrap from 255 to 0.
REQ-018 Piece mode SHALL NOT change long_counter, and background mode SHALL NOT change counter.
REQ-019 update_x_y=1: x_y_pos SHALL increment by 1 (wrap 63 to 0) and counter SHALL clear to 0 on the same edge.
REQ-020 If update_x_y and write are both 1 in a cycle, update_x_y SHALL take priority; no counter increment, and plot SHALL be 0 next cycle.
REQ-021 When write=0 and update_x_y=0, all counters SHALL hold.
REQ-022 Outputs x, y, colour and plot SHALL be registered, with latency 1: they reflect the write sampled on the previous edge.
REQ-023 Pixel coordinates SHALL use the counter values from before the increment in that cycle.
REQ-024 plot SHALL equal the sampled write, except as stated in REQ-020.
REQ-025 Background pixel: x = long_counter[7:0]; y = long_counter[14:8]; colour = 3'b111.
REQ-026 Piece pixel: x = X_ORIGIN + x_y_pos[2:0]*16 + counter[3:0]; y = Y_ORIGIN + x_y_pos[5:3]*16 + counter[7:4].
REQ-027 Piece-pixel arithmetic SHALL be modulo 2^8 for x and 2^7 for y, with no clipping.
REQ-028 Piece colour, highest priority first:
 - turn marker (6'b011100) -> 3'b110;
 - border pixel (counter[3:0]=0 or counter[7:4]=0) -> 3'b000;
 - draw_value=0, with x_y_pos[0]^x_y_pos[3] = 0 -> 3'b010, otherwise 3'b011;
 - draw_value[4]=0 -> 3'b100 (player 1);
 - draw_value[4]=1 -> 3'b001 (player 2).
REQ-029 The block SHALL NOT track the controller's state; behaviour SHALL be fully determined by write, update_x_y and draw_value each cycle.
REQ-030 When plot=0, x, y and colour SHALL hold their last values.

Reset
REQ-031 resetn=0 SHALL immediately force long_counter=0, counter=0, x_y_pos=0, x=0, y=0, colour=0 and plot=0, independent of clk.
REQ-032 Reset asserted mid-frame SHALL abandon the frame; after release, counting SHALL restart from zero on the first qualifying edge.
REQ-033 While resetn=0, write and update_x_y SHALL be ignored.

Verification
REQ-034 Reset, then 3 cycles of write=1, draw_value=6'b011000 -> long_counter=3; plot=1 pixels at (0,0), (1,0), (2,0), each colour 3'b111, each one cycle after its write.
REQ-035 Preload long_counter to 15'h7FFF, then 1 background write -> long_counter=0; pixel (255,127).
REQ-036 x_y_pos=9, 256 piece writes of draw_value=6'b000001:
 - counter returns to 0;
 - first pixel at (32,16), colour 3'b000;
 - pixel for counter=8'h11 at (33,17), colour 3'b100.
REQ-037 x_y_pos=63, then update_x_y=1 with write=1 -> x_y_pos=0, counter=0, plot=0 next cycle.
REQ-038 Empty squares (draw_value=0) at x_y_pos 0 and 1, counter=8'h22 -> colour 3'b010 at pos 0 and 3'b011 at pos 1.
REQ-039 Assert resetn=0 between clock edges during piece writes at counter=100 -> all outputs 0 before the next edge; first write after release draws counter=0.

Source files
------------

// File: rtl/draw_board_datapath.sv
// Board-drawing datapath: turns per-cycle draw requests into VGA pixel writes.
// Two independent counters walk either the full background (long_counter)
// or one 16x16 board square (counter); x_y_pos selects the current square.
// Pixel outputs are registered, one cycle behind the request that made them.
module draw_board_datapath #(
    parameter logic [7:0] X_ORIGIN = 8'd16,
    parameter logic [6:0] Y_ORIGIN = 7'd0
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        write,
    input  logic        update_x_y,
    input  logic [5:0]  draw_value,
    output logic [14:0] long_counter,
    output logic [7:0]  counter,
    output logic [5:0]  x_y_pos,
    output logic [7:0]  x,
    output logic [6:0]  y,
    output logic [2:0]  colour,
    output logic        plot
);

    localparam logic [5:0] BG_CODE   = 6'b011000;
    localparam logic [5:0] TURN_CODE = 6'b011100;

    localparam logic [2:0] COL_BG     = 3'b111;
    localparam logic [2:0] COL_TURN   = 3'b110;
    localparam logic [2:0] COL_BORDER = 3'b000;
    localparam logic [2:0] COL_EMPTY0 = 3'b010;
    localparam logic [2:0] COL_EMPTY1 = 3'b011;
    localparam logic [2:0] COL_P1     = 3'b100;
    localparam logic [2:0] COL_P2     = 3'b001;

    logic [14:0] long_counter_q, long_counter_d;
    logic [7:0]  counter_q, counter_d;
    logic [5:0]  x_y_pos_q, x_y_pos_d;
    logic [7:0]  x_q, x_d;
    logic [6:0]  y_q, y_d;
    logic [2:0]  colour_q, colour_d;
    logic        plot_q, plot_d;

    logic        bg_mode;
    logic        piece_mode;
    logic [7:0]  piece_x;
    logic [6:0]  piece_y;
    logic [2:0]  piece_colour;
    logic        border_pixel;
    logic        empty_parity;

    // Mode decode; advancing to the next square overrides any pixel request.
    always_comb begin
        bg_mode    = 1'b0;
        piece_mode = 1'b0;
        if (write && !update_x_y) begin
            if (draw_value == BG_CODE) begin
                bg_mode = 1'b1;
            end else begin
                piece_mode = 1'b1;
            end
        end
    end

    // Piece pixel position and colour from the pre-increment counter values.
    always_comb begin
        piece_x = X_ORIGIN
                + {1'b0, x_y_pos_q[2:0], 4'b0000}
                + {4'b0000, counter_q[3:0]};
        piece_y = Y_ORIGIN
                + {x_y_pos_q[5:3], 4'b0000}
                + {3'b000, counter_q[7:4]};

        border_pixel = (counter_q[3:0] == 4'd0) || (counter_q[7:4] == 4'd0);
        // Checkerboard: square colour alternates with row+column parity.
        empty_parity = x_y_pos_q[0] ^ x_y_pos_q[3];

        if (draw_value == TURN_CODE) begin
            piece_colour = COL_TURN;
        end else if (border_pixel) begin
            piece_colour = COL_BORDER;
        end else if (draw_value == 6'd0) begin
            piece_colour = empty_parity ? COL_EMPTY1 : COL_EMPTY0;
        end else if (!draw_value[4]) begin
            piece_colour = COL_P1;
        end else begin
            piece_colour = COL_P2;
        end
    end

    // Next-state for counters and the registered pixel outputs.
    always_comb begin
        long_counter_d = long_counter_q;
        counter_d      = counter_q;
        x_y_pos_d      = x_y_pos_q;
        x_d            = x_q;
        y_d            = y_q;
        colour_d       = colour_q;
        plot_d         = 1'b0;

        if (update_x_y) begin
            x_y_pos_d = x_y_pos_q + 6'd1;
            counter_d = 8'd0;
        end else if (bg_mode) begin
            long_counter_d = long_counter_q + 15'd1;
            x_d            = long_counter_q[7:0];
            y_d            = long_counter_q[14:8];
            colour_d       = COL_BG;
            plot_d         = 1'b1;
        end else if (piece_mode) begin
            counter_d = counter_q + 8'd1;
            x_d       = piece_x;
            y_d       = piece_y;
            colour_d  = piece_colour;
            plot_d    = 1'b1;
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            long_counter_q <= 15'd0;
            counter_q      <= 8'd0;
            x_y_pos_q      <= 6'd0;
            x_q            <= 8'd0;
            y_q            <= 7'd0;
            colour_q       <= 3'd0;
            plot_q         <= 1'b0;
        end else begin
            long_counter_q <= long_counter_d;
            counter_q      <= counter_d;
            x_y_pos_q      <= x_y_pos_d;
            x_q            <= x_d;
            y_q            <= y_d;
            colour_q       <= colour_d;
            plot_q         <= plot_d;
        end
    end

    assign long_counter = long_counter_q;
    assign counter      = counter_q;
    assign x_y_pos      = x_y_pos_q;
    assign x            = x_q;
    assign y            = y_q;
    assign colour       = colour_q;
    assign plot         = plot_q;

endmodule
